// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared BCD constants and FSM state encoding. The binary-to-BCD display path
// uses the same digit constants, so they live here rather than in either block.
package bcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_DONE = ST_DONE
  } bcd_state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter: a BCD input channel and a
// binary result channel, each with valid/ready.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic [4*DIGITS-1:0] in_bcd;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    out_bin;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_bcd, in_valid, out_ready,
    input  in_ready, out_bin, out_err, out_valid
  );

  modport slave (
    input  in_bcd, in_valid, out_ready,
    output in_ready, out_bin, out_err, out_valid
  );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// One reverse double-dabble correction: a digit that reached 8 or more after
// the right shift held an extra 3 from the half-weight bit it absorbed.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? (d - BCD_ADJ_SUB) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one
// shift-right-and-adjust step per clock, valid/ready on both sides.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  bcd_state_e         state;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  shifted;
  logic [WORK_W-1:0]  work_nxt;
  logic [BCD_W-1:0]   adj_bcd;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               out_err_r;
  logic [BIN_W-1:0]   out_bin_r;
  logic               bad_digit;
  logic               last_iter;

  // Work register is {bcd_field, bin_field}; bits drain from BCD into binary.
  assign shifted = work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign work_nxt  = {adj_bcd, shifted[BIN_W-1:0]};
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      work        <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      out_bin_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            work       <= {bus.in_bcd, {BIN_W{1'b0}}};
            in_ready_r <= 1'b0;
            if (bad_digit) begin
              state       <= S_DONE;
              out_valid_r <= 1'b1;
              out_err_r   <= 1'b1;
              out_bin_r   <= '0;
            end else begin
              state <= S_CONV;
              cnt   <= '0;
            end
          end
        end
        S_CONV: begin
          work <= work_nxt;
          cnt  <= cnt + CNT_W'(1);
          // The final iteration loads the result directly so DONE follows at once.
          if (last_iter) begin
            state       <= S_DONE;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b0;
            out_bin_r   <= work_nxt[BIN_W-1:0];
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_err   = out_err_r;
  assign bus.out_bin   = out_bin_r;

  // A legal BCD input has been fully drained into the binary field by the last step.
  a_bcd_drained: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == S_CONV && last_iter) |-> (work_nxt[WORK_W-1:BIN_W] == '0)
  );

endmodule
